cell_arbiter: RTL and testbench

Owns the single-port grid cell memory and shares it between the live renderer and the game logic. On every pixel slot with `de` high, the renderer gets a fixed-latency cell lookup. All other cycles go to the game-logic port, which uses a req/grant handshake, or to the internal clear sequencer. Sits between the game FSM and the renderer's future snake/apple overlay stage.

---
 rtl/cell_arbiter_pkg.sv | 25 ++
 rtl/cell_ram.sv | 27 ++
 rtl/cell_arbiter.sv | 173 +++++++++++++++++
 tb/tb_cell_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_arbiter_pkg.sv
// Shared constants for the grid cell store: default grid geometry, cell codes,
// arbiter FSM encodings and the game-coordinate range check.
package cell_arbiter_pkg;

  localparam int unsigned GRID_COLS   = 160;
  localparam int unsigned GRID_ROWS   = 120;
  localparam int unsigned CELL_ADDR_W = 15;
  localparam int unsigned CELL_W_DEF  = 2;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_SNAKE = 2'd1,
    CELL_HEAD  = 2'd2,
    CELL_APPLE = 2'd3
  } cell_code_e;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  function automatic logic in_grid(input logic [7:0] x, input logic [6:0] y,
                                   input int unsigned cols, input int unsigned rows);
    return (32'(x) < cols) && (32'(y) < rows);
  endfunction

endpackage

// File: rtl/cell_ram.sv
// Single-port synchronous cell RAM with registered read data; written so that
// synthesis maps it onto block RAM (no reset on the array or read register).
module cell_ram #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned CELL_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [CELL_W-1:0] wdata,
  output logic [CELL_W-1:0] rdata
);

  logic [CELL_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [CELL_W-1:0] rdata_q;

  // Read-first port: write the addressed cell and register its old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cell_arbiter.sv
// Shares the cell RAM between the renderer (absolute priority on de pixel
// slots), the game-logic req/grant port and the whole-grid clear sweep.
module cell_arbiter
  import cell_arbiter_pkg::*;
#(
  parameter int unsigned COLS   = GRID_COLS,
  parameter int unsigned ROWS   = GRID_ROWS,
  parameter int unsigned ADDR_W = CELL_ADDR_W,
  parameter int unsigned CELL_W = CELL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic              de,
  input  logic [7:0]        gx,
  input  logic [6:0]        gy,
  output logic [CELL_W-1:0] r_cell,
  output logic              r_cell_vld,
  input  logic              g_req,
  input  logic              g_we,
  input  logic [7:0]        g_x,
  input  logic [6:0]        g_y,
  input  logic [CELL_W-1:0] g_wdata,
  output logic              g_gnt,
  output logic [CELL_W-1:0] g_rdata,
  output logic              g_rvalid,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
  localparam logic [CELL_W-1:0] EMPTY     = CELL_W'(CELL_EMPTY);

  logic              render_s;
  logic              g_in_range_s;
  logic [ADDR_W-1:0] r_addr_s;
  logic [ADDR_W-1:0] g_addr_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [CELL_W-1:0] ram_wdata_s;
  logic [CELL_W-1:0] ram_rdata_s;
  logic              g_gnt_s;
  logic [CELL_W-1:0] r_cell_s;
  logic [CELL_W-1:0] g_rdata_s;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              busy_q, busy_d;
  logic              clr_done_q, clr_done_d;
  logic              r_vld_q, r_vld_d;
  logic              g_rvalid_q, g_rvalid_d;
  logic              g_oor_q, g_oor_d;
  logic [CELL_W-1:0] r_cell_q;
  logic [CELL_W-1:0] g_rdata_q;

  assign render_s     = pix_en & de;
  assign g_in_range_s = in_grid(g_x, g_y, COLS, ROWS);
  assign r_addr_s     = ADDR_W'(gy) * ADDR_W'(COLS) + ADDR_W'(gx);
  assign g_addr_s     = ADDR_W'(g_y) * ADDR_W'(COLS) + ADDR_W'(g_x);

  cell_ram #(
    .ADDR_W (ADDR_W),
    .CELL_W (CELL_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  // Port arbitration, clear sweep and next-state logic.
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_done_d  = 1'b0;
    g_rvalid_d  = 1'b0;
    g_oor_d     = g_oor_q;
    g_gnt_s     = 1'b0;
    ram_we_s    = 1'b0;
    ram_addr_s  = r_addr_s;
    ram_wdata_s = g_wdata;
    case (state_q)
      ST_IDLE: begin
        // clr_start is honoured even in a render slot so the pulse is never lost.
        if (clr_start) begin
          state_d    = ST_CLEAR;
          clr_addr_d = {ADDR_W{1'b0}};
        end else if (g_req && !render_s) begin
          g_gnt_s    = 1'b1;
          ram_addr_s = g_in_range_s ? g_addr_s : {ADDR_W{1'b0}};
          ram_we_s   = g_we & g_in_range_s;
          g_rvalid_d = ~g_we;
          g_oor_d    = ~g_in_range_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (!render_s) begin
          ram_we_s    = 1'b1;
          ram_addr_s  = clr_addr_q;
          ram_wdata_s = EMPTY;
          if (clr_addr_q == LAST_ADDR) begin
            state_d    = ST_IDLE;
            clr_done_d = 1'b1;
          end else begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
          end
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d    = ST_CLEAR;
        clr_addr_d = {ADDR_W{1'b0}};
      end
    endcase
    busy_d  = (state_d == ST_CLEAR);
    r_vld_d = render_s;
  end

  // Read data is live from the RAM in the pulse cycle and held afterwards.
  always_comb begin
    r_cell_s  = r_cell_q;
    g_rdata_s = g_rdata_q;
    if (r_vld_q) begin
      r_cell_s = ram_rdata_s;
    end else begin
      r_cell_s = r_cell_q;
    end
    if (g_rvalid_q) begin
      g_rdata_s = g_oor_q ? EMPTY : ram_rdata_s;
    end else begin
      g_rdata_s = g_rdata_q;
    end
  end

  // State, counter and output registers; reset launches an auto-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= {ADDR_W{1'b0}};
      busy_q     <= 1'b1;
      clr_done_q <= 1'b0;
      r_vld_q    <= 1'b0;
      g_rvalid_q <= 1'b0;
      g_oor_q    <= 1'b0;
      r_cell_q   <= EMPTY;
      g_rdata_q  <= EMPTY;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
      clr_done_q <= clr_done_d;
      r_vld_q    <= r_vld_d;
      g_rvalid_q <= g_rvalid_d;
      g_oor_q    <= g_oor_d;
      r_cell_q   <= r_cell_s;
      g_rdata_q  <= g_rdata_s;
    end
  end

  assign g_gnt      = g_gnt_s;
  assign r_cell     = r_cell_s;
  assign r_cell_vld = r_vld_q;
  assign g_rdata    = g_rdata_s;
  assign g_rvalid   = g_rvalid_q;
  assign busy       = busy_q;
  assign clr_done   = clr_done_q;

endmodule

// File: tb/tb_cell_arbiter.sv
// Bench for cell_arbiter on an 8x4 grid: directed handshake/clear/reset
// sequences, a table of game accesses, and a randomized run against a grid model.
module tb_cell_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_en, de;
  logic [7:0] gx;
  logic [6:0] gy;
  logic [1:0] r_cell;
  logic       r_cell_vld;
  logic       g_req, g_we;
  logic [7:0] g_x;
  logic [6:0] g_y;
  logic [1:0] g_wdata;
  logic       g_gnt;
  logic [1:0] g_rdata;
  logic       g_rvalid;
  logic       clr_start, busy, clr_done;

  int checks = 0;
  int errors = 0;
  int phase  = 0;
  bit auto_pix = 1'b1;

  typedef struct {
    bit         we;
    int         x;
    int         y;
    logic [1:0] wd;
    logic [1:0] exp_d;
  } op_t;
  op_t ops [10];

  logic [1:0] mem_m [0:31];

  always #5 clk = ~clk;

  cell_arbiter #(.COLS(8), .ROWS(4), .ADDR_W(5), .CELL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .de(de), .gx(gx), .gy(gy),
    .r_cell(r_cell), .r_cell_vld(r_cell_vld), .g_req(g_req), .g_we(g_we),
    .g_x(g_x), .g_y(g_y), .g_wdata(g_wdata), .g_gnt(g_gnt), .g_rdata(g_rdata),
    .g_rvalid(g_rvalid), .clr_start(clr_start), .busy(busy), .clr_done(clr_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (auto_pix) begin
      phase  = (phase + 1) % 4;
      pix_en = (phase == 0);
    end
  endtask

  task automatic game_op(input bit we, input int x, input int y,
                         input logic [1:0] wd, input logic [1:0] exp_d);
    int waited;
    bit got;
    waited = 0;
    got = 1'b0;
    g_req = 1'b1; g_we = we; g_x = 8'(x); g_y = 7'(y); g_wdata = wd;
    while (!got && waited < 64) begin
      #1;
      got = g_gnt;
      cyc();
      waited++;
    end
    g_req = 1'b0;
    chk("gnt_seen", got, 1'b1);
    if (got && !we) begin
      chk("op_rvalid", g_rvalid, 1'b1);
      chk("op_rdata", g_rdata, exp_d);
    end else begin
      chk("op_no_rvalid", g_rvalid, 1'b0);
    end
  endtask

  // Runs until clr_done; restart_at >= 0 pulses clr_start after that many writes.
  task automatic run_clear(input int restart_at);
    int nr, cycles;
    bit done, slot;
    nr = 0; cycles = 0; done = 1'b0;
    while (!done && cycles < 400) begin
      slot = pix_en & de;
      #1;
      if (g_req) chk("gnt_during_clear", g_gnt, 1'b0);
      cyc();
      cycles++;
      clr_start = 1'b0;
      if (!slot) nr++;
      if (!slot && nr == restart_at) clr_start = 1'b1;
      if (clr_done) begin
        done = 1'b1;
        chk("clr_len", nr, 32);
        chk("busy_after_clear", busy, 1'b0);
      end else begin
        chk("busy_during_clear", busy, 1'b1);
      end
    end
    clr_start = 1'b0;
    chk("clr_finished", done, 1'b1);
  endtask

  initial begin
    bit pend, pwe, slot, exp_gnt, inr, have_r, have_g;
    bit e_rvld, e_grv, e_done, e_busy, m_clr;
    int px, py, midx, nr, guard;
    logic [1:0] pwd, e_rcell, e_grd;

    ops[0] = '{1'b0, 0, 0, 2'd0, 2'd0};
    ops[1] = '{1'b0, 7, 3, 2'd0, 2'd0};
    ops[2] = '{1'b1, 3, 2, 2'd3, 2'd0};
    ops[3] = '{1'b0, 3, 2, 2'd0, 2'd3};
    ops[4] = '{1'b1, 8, 0, 2'd1, 2'd0};
    ops[5] = '{1'b0, 0, 1, 2'd0, 2'd0};
    ops[6] = '{1'b0, 8, 0, 2'd0, 2'd0};
    ops[7] = '{1'b1, 7, 3, 2'd2, 2'd0};
    ops[8] = '{1'b0, 7, 3, 2'd0, 2'd2};
    ops[9] = '{1'b0, 2, 4, 2'd0, 2'd0};

    rst_n = 1'b1; pix_en = 1'b0; de = 1'b0; gx = 8'd0; gy = 7'd0;
    g_req = 1'b0; g_we = 1'b0; g_x = 8'd0; g_y = 7'd0; g_wdata = 2'd0; clr_start = 1'b0;
    #3 rst_n = 1'b0;
    g_req = 1'b1;
    #3;
    chk("rst_busy", busy, 1'b1);
    chk("rst_gnt", g_gnt, 1'b0);
    chk("rst_rvalid", g_rvalid, 1'b0);
    chk("rst_rvld", r_cell_vld, 1'b0);
    chk("rst_done", clr_done, 1'b0);
    chk("rst_rcell", r_cell, 2'd0);
    chk("rst_grdata", g_rdata, 2'd0);
    g_req = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    run_clear(-1);

    for (int i = 0; i < 10; i++) begin
      game_op(ops[i].we, ops[i].x, ops[i].y, ops[i].wd, ops[i].exp_d);
    end

    // Render slot, hold between pulses, de=0 slot.
    auto_pix = 1'b0; pix_en = 1'b1; de = 1'b1; gx = 8'd3; gy = 7'd2;
    cyc();
    chk("render_vld", r_cell_vld, 1'b1);
    chk("render_cell", r_cell, 2'd3);
    pix_en = 1'b0; de = 1'b0;
    cyc();
    chk("render_vld_gone", r_cell_vld, 1'b0);
    chk("render_hold", r_cell, 2'd3);
    pix_en = 1'b1; de = 1'b0; gx = 8'd7; gy = 7'd3;
    cyc();
    chk("de0_no_vld", r_cell_vld, 1'b0);
    pix_en = 1'b0;

    // Write granted at t is seen by a render read at t+1.
    g_req = 1'b1; g_we = 1'b1; g_x = 8'd5; g_y = 7'd1; g_wdata = 2'd2;
    #1 chk("wr_gnt", g_gnt, 1'b1);
    cyc();
    g_req = 1'b0; pix_en = 1'b1; de = 1'b1; gx = 8'd5; gy = 7'd1;
    cyc();
    chk("wr_then_render", r_cell, 2'd2);

    // Request held across a render slot.
    g_req = 1'b1; g_we = 1'b0; g_x = 8'd3; g_y = 7'd2; gx = 8'd7; gy = 7'd3;
    #1 chk("gnt_in_slot", g_gnt, 1'b0);
    cyc();
    chk("slot_render", r_cell, 2'd2);
    pix_en = 1'b0;
    #1 chk("gnt_after_slot", g_gnt, 1'b1);
    cyc();
    g_req = 1'b0;
    chk("held_rvalid", g_rvalid, 1'b1);
    chk("held_rdata", g_rdata, 2'd3);
    cyc();
    chk("rvalid_pulse", g_rvalid, 1'b0);
    chk("rdata_hold", g_rdata, 2'd3);

    // clr_start with a pending request, re-pulsed mid-sweep.
    auto_pix = 1'b1; de = 1'b1; gx = 8'd6; gy = 7'd3;
    game_op(1'b1, 1, 1, 2'd1, 2'd0);
    g_req = 1'b1; g_we = 1'b0; g_x = 8'd7; g_y = 7'd3; clr_start = 1'b1;
    #1 chk("gnt_with_clr_start", g_gnt, 1'b0);
    cyc();
    clr_start = 1'b0;
    run_clear(10);
    de = 1'b0;
    #1 chk("gnt_after_clear", g_gnt, 1'b1);
    cyc();
    g_req = 1'b0;
    chk("pending_rvalid", g_rvalid, 1'b1);
    chk("pending_rdata", g_rdata, 2'd0);
    for (int a = 0; a < 32; a++) begin
      game_op(1'b0, a % 8, a / 8, 2'd0, 2'd0);
    end

    // Reset in the middle of a sweep.
    g_req = 1'b0; de = 1'b1; clr_start = 1'b1;
    cyc();
    clr_start = 1'b0;
    nr = 0; guard = 0;
    while (nr < 10 && guard < 100) begin
      if (!(pix_en & de)) nr++;
      cyc();
      guard++;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b1);
    chk("midrst_done", clr_done, 1'b0);
    chk("midrst_rcell", r_cell, 2'd0);
    cyc(); cyc();
    chk("midrst_busy_held", busy, 1'b1);
    rst_n = 1'b1;
    run_clear(-1);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("done_once", clr_done, 1'b0);
    end

    // Randomized traffic against a grid model.
    for (int a = 0; a < 32; a++) mem_m[a] = 2'd0;
    pend = 0; m_clr = 0; midx = 0; have_r = 0; have_g = 0;
    pwe = 0; px = 0; py = 0; pwd = 2'd0; e_rcell = 2'd0; e_grd = 2'd0;
    for (int c = 0; c < 2000; c++) begin
      de = ($urandom_range(0, 3) != 0);
      gx = 8'($urandom_range(0, 7));
      gy = 7'($urandom_range(0, 3));
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1'b1;
        pwe  = 1'($urandom_range(0, 1));
        px   = $urandom_range(0, 9);
        py   = $urandom_range(0, 4);
        pwd  = 2'($urandom_range(0, 3));
      end
      g_req = pend; g_we = pwe; g_x = 8'(px); g_y = 7'(py); g_wdata = pwd;
      clr_start = ($urandom_range(0, 299) == 0);
      slot = pix_en & de;
      exp_gnt = pend && !slot && !m_clr && !clr_start;
      #1 chk("rnd_gnt", g_gnt, exp_gnt);
      e_rvld = slot;
      if (slot) begin
        e_rcell = mem_m[int'(gy) * 8 + int'(gx)];
        have_r = 1'b1;
      end
      e_grv = 1'b0;
      if (exp_gnt) begin
        inr = (px < 8) && (py < 4);
        if (pwe) begin
          if (inr) mem_m[py * 8 + px] = pwd;
        end else begin
          e_grv = 1'b1;
          e_grd = inr ? mem_m[py * 8 + px] : 2'd0;
          have_g = 1'b1;
        end
        pend = 1'b0;
      end
      e_done = 1'b0;
      if (m_clr) begin
        if (!slot) begin
          mem_m[midx] = 2'd0;
          if (midx == 31) begin
            m_clr = 1'b0;
            e_done = 1'b1;
          end else begin
            midx++;
          end
        end
      end else if (clr_start) begin
        m_clr = 1'b1;
        midx = 0;
      end
      e_busy = m_clr;
      cyc();
      chk("rnd_rvld", r_cell_vld, e_rvld);
      chk("rnd_grvalid", g_rvalid, e_grv);
      chk("rnd_done", clr_done, e_done);
      chk("rnd_busy", busy, e_busy);
      if (have_r) chk("rnd_rcell", r_cell, e_rcell);
      if (have_g) chk("rnd_grdata", g_rdata, e_grd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
